// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone arbiter with round-robin priority.
// A grant is held for the whole cyc of its owner, so multi-word bursts
// from one master are never interleaved with the other.
// The state register doubles as the one-hot grant (IDLE=00, GNT0=01,
// GNT1=10), so o_grant is the FSM state exposed directly.
// Optional stall watchdog: define WB_ARB_WATCHDOG_EN to enable it.
//
// Handshake: each master raises cyc to request the bus and stb for each
// beat. A beat completes in the cycle where ack (or err) is high while
// stb is high and the master owns the grant. A non-owner keeps its
// cyc/stb asserted and waits; it never sees ack or err.
module wb_arbiter2 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_resetn,

    input  logic [31:0] s0_wb_adr_i,
    input  logic [31:0] s0_wb_dat_i,
    output logic [31:0] s0_wb_dat_o,
    input  logic        s0_wb_we_i,
    input  logic [3:0]  s0_wb_sel_i,
    input  logic        s0_wb_stb_i,
    input  logic        s0_wb_cyc_i,
    output logic        s0_wb_ack_o,
    output logic        s0_wb_err_o,

    input  logic [31:0] s1_wb_adr_i,
    input  logic [31:0] s1_wb_dat_i,
    output logic [31:0] s1_wb_dat_o,
    input  logic        s1_wb_we_i,
    input  logic [3:0]  s1_wb_sel_i,
    input  logic        s1_wb_stb_i,
    input  logic        s1_wb_cyc_i,
    output logic        s1_wb_ack_o,
    output logic        s1_wb_err_o,

    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    input  logic [31:0] m_wb_dat_i,
    output logic        m_wb_we_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_stb_o,
    output logic        m_wb_cyc_o,
    input  logic        m_wb_ack_i,
    input  logic        m_wb_err_i,

    output logic [1:0]  o_grant,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state;
    logic   last;       // master granted most recently; the other wins a tie
    logic   owner_stb;  // owner's strobe before watchdog masking
    logic   wd_err;

    // Arbitration FSM: grant on request, hold until the owner drops cyc.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_wb_cyc_i && s1_wb_cyc_i) begin
                        state <= last ? GNT0 : GNT1;
                    end else if (s0_wb_cyc_i) begin
                        state <= GNT0;
                    end else if (s1_wb_cyc_i) begin
                        state <= GNT1;
                    end
                end
                GNT0: begin
                    if (!s0_wb_cyc_i) begin
                        state <= IDLE;
                        last  <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!s1_wb_cyc_i) begin
                        state <= IDLE;
                        last  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_grant = state;
    assign o_busy  = (state != IDLE);

    // Downstream mux selected by the registered grant; all zero when idle.
    always_comb begin
        m_wb_adr_o = 32'h0;
        m_wb_dat_o = 32'h0;
        m_wb_we_o  = 1'b0;
        m_wb_sel_o = 4'h0;
        owner_stb  = 1'b0;
        m_wb_cyc_o = 1'b0;
        case (state)
            GNT0: begin
                m_wb_adr_o = s0_wb_adr_i;
                m_wb_dat_o = s0_wb_dat_i;
                m_wb_we_o  = s0_wb_we_i;
                m_wb_sel_o = s0_wb_sel_i;
                owner_stb  = s0_wb_stb_i;
                m_wb_cyc_o = 1'b1;
            end
            GNT1: begin
                m_wb_adr_o = s1_wb_adr_i;
                m_wb_dat_o = s1_wb_dat_i;
                m_wb_we_o  = s1_wb_we_i;
                m_wb_sel_o = s1_wb_sel_i;
                owner_stb  = s1_wb_stb_i;
                m_wb_cyc_o = 1'b1;
            end
            default: ;
        endcase
    end

    // The watchdog cycle withdraws the strobe so the slave cannot also
    // complete the beat while the master is being told it failed.
    assign m_wb_stb_o = owner_stb & ~wd_err;

`ifdef WB_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt;

    assign wd_err = owner_stb && !m_wb_ack_i && !m_wb_err_i &&
                    (wd_cnt == 16'(TIMEOUT_CYCLES));

    // Count stalled strobe cycles; any response, idle or a fire restarts it.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            wd_cnt <= 16'h0;
        end else if (state == IDLE || m_wb_ack_i || m_wb_err_i || wd_err) begin
            wd_cnt <= 16'h0;
        end else if (owner_stb) begin
            wd_cnt <= wd_cnt + 16'h1;
        end
    end
`else
    logic [15:0] wd_limit_unused;

    assign wd_limit_unused = 16'(TIMEOUT_CYCLES);
    assign wd_err          = 1'b0;
`endif

    // Responses reach only the owner; read data is broadcast ungated.
    assign s0_wb_ack_o = m_wb_ack_i & o_grant[0];
    assign s1_wb_ack_o = m_wb_ack_i & o_grant[1];
    assign s0_wb_err_o = (m_wb_err_i | wd_err) & o_grant[0];
    assign s1_wb_err_o = (m_wb_err_i | wd_err) & o_grant[1];
    assign s0_wb_dat_o = m_wb_dat_i;
    assign s1_wb_dat_o = m_wb_dat_i;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed bench for wb_arbiter2.
// Inputs change 2 time units after each rising edge and outputs are
// sampled 2 units later, well clear of the next edge.
module tb_wb_arbiter2;

    logic        i_clk;
    logic        i_resetn;
    logic [31:0] s0_wb_adr_i, s0_wb_dat_i, s0_wb_dat_o;
    logic        s0_wb_we_i, s0_wb_stb_i, s0_wb_cyc_i, s0_wb_ack_o, s0_wb_err_o;
    logic [3:0]  s0_wb_sel_i;
    logic [31:0] s1_wb_adr_i, s1_wb_dat_i, s1_wb_dat_o;
    logic        s1_wb_we_i, s1_wb_stb_i, s1_wb_cyc_i, s1_wb_ack_o, s1_wb_err_o;
    logic [3:0]  s1_wb_sel_i;
    logic [31:0] m_wb_adr_o, m_wb_dat_o, m_wb_dat_i;
    logic        m_wb_we_o, m_wb_stb_o, m_wb_cyc_o, m_wb_ack_i, m_wb_err_i;
    logic [3:0]  m_wb_sel_o;
    logic [1:0]  o_grant;
    logic        o_busy;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    int          err_seen;

    wb_arbiter2 #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk       (i_clk),
        .i_resetn    (i_resetn),
        .s0_wb_adr_i (s0_wb_adr_i),
        .s0_wb_dat_i (s0_wb_dat_i),
        .s0_wb_dat_o (s0_wb_dat_o),
        .s0_wb_we_i  (s0_wb_we_i),
        .s0_wb_sel_i (s0_wb_sel_i),
        .s0_wb_stb_i (s0_wb_stb_i),
        .s0_wb_cyc_i (s0_wb_cyc_i),
        .s0_wb_ack_o (s0_wb_ack_o),
        .s0_wb_err_o (s0_wb_err_o),
        .s1_wb_adr_i (s1_wb_adr_i),
        .s1_wb_dat_i (s1_wb_dat_i),
        .s1_wb_dat_o (s1_wb_dat_o),
        .s1_wb_we_i  (s1_wb_we_i),
        .s1_wb_sel_i (s1_wb_sel_i),
        .s1_wb_stb_i (s1_wb_stb_i),
        .s1_wb_cyc_i (s1_wb_cyc_i),
        .s1_wb_ack_o (s1_wb_ack_o),
        .s1_wb_err_o (s1_wb_err_o),
        .m_wb_adr_o  (m_wb_adr_o),
        .m_wb_dat_o  (m_wb_dat_o),
        .m_wb_dat_i  (m_wb_dat_i),
        .m_wb_we_o   (m_wb_we_o),
        .m_wb_sel_o  (m_wb_sel_o),
        .m_wb_stb_o  (m_wb_stb_o),
        .m_wb_cyc_o  (m_wb_cyc_o),
        .m_wb_ack_i  (m_wb_ack_i),
        .m_wb_err_i  (m_wb_err_i),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    // Clock and run-time guard.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // Driver tasks.
    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
        s0_wb_cyc_i = cyc;
        s0_wb_stb_i = stb;
        s0_wb_we_i  = we;
        s0_wb_adr_i = adr;
        s0_wb_dat_i = dat;
        s0_wb_sel_i = 4'hF;
    endtask

    task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
        s1_wb_cyc_i = cyc;
        s1_wb_stb_i = stb;
        s1_wb_we_i  = we;
        s1_wb_adr_i = adr;
        s1_wb_dat_i = dat;
        s1_wb_sel_i = 4'hF;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        m_wb_ack_i = 1'b0;
        m_wb_err_i = 1'b0;
        m_wb_dat_i = 32'h0;
        i_resetn   = 1'b0;
        step();
        step();
        check("rst_grant", {30'h0, o_grant}, 32'h0);
        check("rst_busy",  {31'h0, o_busy}, 32'h0);
        check("rst_cyc",   {31'h0, m_wb_cyc_o}, 32'h0);
        i_resetn = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single master read.
        step();
        drive_m0(1'b1, 1'b1, 1'b0, 32'h11223344, 32'h0);
        settle();
        check("t1_grant_lat", {30'h0, o_grant}, 32'h0);
        step();
        check("t1_grant", {30'h0, o_grant}, 32'h1);
        check("t1_adr", m_wb_adr_o, 32'h11223344);
        check("t1_cyc", {31'h0, m_wb_cyc_o}, 32'h1);
        check("t1_busy", {31'h0, o_busy}, 32'h1);
        step();
        m_wb_ack_i = 1'b1;
        m_wb_dat_i = 32'hFFEEDDCC;
        settle();
        check("t1_ack0", {31'h0, s0_wb_ack_o}, 32'h1);
        check("t1_dat0", s0_wb_dat_o, 32'hFFEEDDCC);
        check("t1_ack1", {31'h0, s1_wb_ack_o}, 32'h0);
        step();
        m_wb_ack_i = 1'b0;
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("t1_release", {30'h0, o_grant}, 32'h0);

        // Simultaneous first request after reset.
        do_reset();
        step();
        drive_m0(1'b1, 1'b1, 1'b0, 32'hA0000000, 32'h0);
        drive_m1(1'b1, 1'b1, 1'b0, 32'hB0000000, 32'h0);
        step();
        check("t2_first", {30'h0, o_grant}, 32'h1);
        m_wb_ack_i = 1'b1;
        settle();
        check("t2_nonowner_ack", {31'h0, s1_wb_ack_o}, 32'h0);
        m_wb_ack_i = 1'b0;
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("t2_idle_gap", {30'h0, o_grant}, 32'h0);
        check("t2_idle_stb", {31'h0, m_wb_stb_o}, 32'h0);
        step();
        check("t2_second", {30'h0, o_grant}, 32'h2);
        check("t2_adr1", m_wb_adr_o, 32'hB0000000);
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("t2_release", {30'h0, o_grant}, 32'h0);

        // Burst lock: master 0 writes 4 words, master 1 waits throughout.
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        drive_m0(1'b1, 1'b1, 1'b1, 32'h100, 32'h55);
        drive_m1(1'b1, 1'b1, 1'b0, 32'hDEAD0000, 32'h0);
        step();
        check("t3_grant", {30'h0, o_grant}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            drive_m0(1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'h55 + 32'(17 * i));
            m_wb_ack_i = 1'b1;
            settle();
            exp_v = exp_q.pop_front();
            check("t3_adr", m_wb_adr_o, exp_v);
            check("t3_dat", m_wb_dat_o, 32'h55 + 32'(17 * i));
            check("t3_we",  {31'h0, m_wb_we_o}, 32'h1);
            check("t3_sel", {28'h0, m_wb_sel_o}, 32'hF);
            check("t3_ack0", {31'h0, s0_wb_ack_o}, 32'h1);
            check("t3_ack1", {31'h0, s1_wb_ack_o}, 32'h0);
            step();
        end
        m_wb_ack_i = 1'b0;
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        settle();
        check("t3_hold", {30'h0, o_grant}, 32'h1);
        step();
        check("t3_gap", {30'h0, o_grant}, 32'h0);
        step();
        check("t3_m1", {30'h0, o_grant}, 32'h2);
        check("t3_m1_adr", m_wb_adr_o, 32'hDEAD0000);
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("t3_release", {30'h0, o_grant}, 32'h0);

        // Round-robin: both request continuously, one word per tenure.
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        drive_m0(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        drive_m1(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        for (int r = 0; r < 4; r++) begin
            step();
            exp_v = exp_q.pop_front();
            check("t4_grant", {30'h0, o_grant}, exp_v);
            m_wb_ack_i = 1'b1;
            settle();
            check("t4_ack0", {31'h0, s0_wb_ack_o}, {31'h0, exp_v[0]});
            check("t4_ack1", {31'h0, s1_wb_ack_o}, {31'h0, exp_v[1]});
            step();
            m_wb_ack_i = 1'b0;
            if (exp_v[0]) drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            else          drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            settle();
            check("t4_hold", {30'h0, o_grant}, exp_v);
            step();
            check("t4_gap", {30'h0, o_grant}, 32'h0);
            if (exp_v[0]) drive_m0(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
            else          drive_m1(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
        end

        // Watchdog on a slave that never responds.
        do_reset();
        step();
        drive_m0(1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
        step();
        err_seen = 0;
`ifdef WB_ARB_WATCHDOG_EN
        for (int k = 0; k < 13; k++) begin
            if (s0_wb_err_o) err_seen++;
            if (k == 8) begin
                check("t5_err_at8", {31'h0, s0_wb_err_o}, 32'h1);
                check("t5_stb_at8", {31'h0, m_wb_stb_o}, 32'h0);
            end else begin
                check("t5_err_off", {31'h0, s0_wb_err_o}, 32'h0);
                check("t5_stb_on", {31'h0, m_wb_stb_o}, 32'h1);
            end
            check("t5_err1", {31'h0, s1_wb_err_o}, 32'h0);
            step();
        end
        check("t5_err_count", 32'(err_seen), 32'h1);
        check("t5_grant_kept", {30'h0, o_grant}, 32'h1);
`else
        for (int k = 0; k < 20; k++) begin
            if (s0_wb_err_o) err_seen++;
            step();
        end
        check("t5_no_err", 32'(err_seen), 32'h0);
        check("t5_stb_held", {31'h0, m_wb_stb_o}, 32'h1);
`endif
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        check("t5_release", {30'h0, o_grant}, 32'h0);

        // Reset during master 1's second word.
        drive_m1(1'b1, 1'b1, 1'b1, 32'h500, 32'h1);
        step();
        check("t6_grant", {30'h0, o_grant}, 32'h2);
        m_wb_ack_i = 1'b1;
        settle();
        check("t6_ack1", {31'h0, s1_wb_ack_o}, 32'h1);
        step();
        drive_m1(1'b1, 1'b1, 1'b1, 32'h504, 32'h2);
        i_resetn = 1'b0;
        step();
        check("t6_rst_grant", {30'h0, o_grant}, 32'h0);
        check("t6_rst_cyc", {31'h0, m_wb_cyc_o}, 32'h0);
        check("t6_rst_busy", {31'h0, o_busy}, 32'h0);
        check("t6_rst_stb", {31'h0, m_wb_stb_o}, 32'h0);
        check("t6_rst_adr", m_wb_adr_o, 32'h0);
        check("t6_rst_ack", {31'h0, s1_wb_ack_o}, 32'h0);
        m_wb_ack_i = 1'b0;
        i_resetn   = 1'b1;
        drive_m0(1'b1, 1'b1, 1'b0, 32'h600, 32'h0);
        step();
        check("t6_after", {30'h0, o_grant}, 32'h1);
        drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone arbiter sharing a single downstream Wishbone bus between the SPI bridge master (master 0) and a second on-chip master (master 1, e.g. a UART bridge or a DMA engine). Grants are round-robin and locked for the whole `cyc` cycle, so the bridge's multi-word read and write bursts are never interleaved. An optional watchdog terminates stalled cycles with an error.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles `m_wb_stb_o` may stay high without `ack`/`err` before the watchdog fires. Range 1–65535.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_resetn`  in  1  reset, synchronous and active-low.
- `s0_wb_adr_i`  in  32  master 0 address.
- `s0_wb_dat_i`  in  32  master 0 write data.
- `s0_wb_dat_o`  out  32  master 0 read data.
- `s0_wb_we_i`  in  1  master 0 write enable.
- `s0_wb_sel_i`  in  4  master 0 byte select.
- `s0_wb_stb_i`  in  1  master 0 strobe.
- `s0_wb_cyc_i`  in  1  master 0 cycle; doubles as the bus request.
- `s0_wb_ack_o`  out  1  master 0 acknowledge.
- `s0_wb_err_o`  out  1  master 0 error.
- `s1_wb_*`: same set and widths as `s0_wb_*`, for master 1.
- `m_wb_adr_o`  out  32  downstream address.
- `m_wb_dat_o`  out  32  downstream write data.
- `m_wb_dat_i`  in  32  downstream read data.
- `m_wb_we_o`  out  1  downstream write enable.
- `m_wb_sel_o`  out  4  downstream byte select.
- `m_wb_stb_o`  out  1  downstream strobe.
- `m_wb_cyc_o`  out  1  downstream cycle.
- `m_wb_ack_i`  in  1  downstream acknowledge.
- `m_wb_err_i`  in  1  downstream error.
- `o_grant`  out  2  one-hot current owner; bit 0 is master 0, bit 1 is master 1.
- `o_busy`  out  1  high whenever `o_grant` is non-zero.

## Operation
- **States:**
  - `IDLE` (`o_grant=00`)
  - `GNT0` (`o_grant=01`)
  - `GNT1` (`o_grant=10`)
- **Priority pointer:** 1-bit `last` register; reset value 1, so master 0 wins the first arbitration.
- **Transitions from `IDLE`:**
  - Only one `sN_wb_cyc_i` high: go to `GNTN`.
  - Both high: grant the master that was *not* granted last.
  - Both low: stay in `IDLE`.
- **Transitions from `GNTN`:**
  - Stay while `sN_wb_cyc_i`=1.
  - When it is sampled low, go to `IDLE` and set `last`=N.
- **Outputs while granted:**
  - `m_wb_adr/dat/we/sel/stb/cyc_o` mux the owner's inputs combinationally, selected from the registered grant.
  - `m_wb_cyc_o`=1.
- **Outputs in `IDLE`:** all `m_wb_*_o` driven 0.
- **Responses:**
  - `sN_wb_ack_o` = `m_wb_ack_i` & `grant[N]`.
  - `sN_wb_err_o` = (`m_wb_err_i` | `wd_err`) & `grant[N]`.
  - A non-owner never sees ack or err.
- **Read data:** `sN_wb_dat_o` = `m_wb_dat_i` for both masters, ungated. It is only meaningful with ack.
- **Non-owner handshake:** a non-owner holding `cyc`/`stb` simply waits; no state is lost.

## Timing
- **Grant latency:** request sampled at edge N, grant registered at edge N+1. `m_wb_cyc_o` rises in the cycle after N+1's edge, i.e. 1 cycle of latency.
- **Release:** owner drops `cyc` before edge N; `IDLE` at edge N+1. The earliest next grant is at edge N+2, so there is exactly one idle bus cycle between owners.
- **Back-to-back:** the same master re-requesting while the other is waiting loses to the other, per round-robin.
- **Reset:** at an edge with `i_resetn`=0:
  - state → `IDLE`, `last` → 1, watchdog counter → 0.
  - All outputs read 0 after that edge, including mid-burst.
  - A downstream ack arriving after reset is ignored.
- **Owner drops `cyc` with `stb` still high:** legal. Outputs follow the combinational mux until the `IDLE` edge.

## Configuration
- **Macro:** `WB_ARB_WATCHDOG_EN`.
- **Defined:**
  - A 16-bit counter increments each cycle with `m_wb_stb_o`=1 and `m_wb_ack_i`=`m_wb_err_i`=0.
  - It clears on ack, err, `IDLE`, or reset.
  - When the counter equals `TIMEOUT_CYCLES`, `wd_err` pulses for one cycle and `m_wb_stb_o` is forced 0 in that cycle. The counter then clears.
  - The grant is retained; the owner must drop `cyc`.
- **Undefined:** no counter, `wd_err`≡0, `TIMEOUT_CYCLES` unused. Cycles may stall indefinitely.

## Test plan
- **Single master:** master 0 read of 0x11223344; slave acks 1 cycle later with 0xFFEEDDCC → `o_grant`=01 one cycle after `s0_wb_cyc_i`. `s0_wb_dat_o`=0xFFEEDDCC with `s0_wb_ack_o`; `s1_wb_ack_o` stays 0.
- **Simultaneous first request:** both raise `cyc` in the same cycle after reset → master 0 granted first. After master 0 drops `cyc`: one `IDLE` cycle, then `o_grant`=10.
- **Burst lock:** master 0 performs 4 writes (0x55,0x66,0x77,0x88) under one `cyc` while master 1 requests throughout → `m_wb_adr_o` shows only master 0's address until the 4th ack and the `cyc` drop; master 1 is granted 2 edges later.
- **Round-robin fairness:** both masters request continuously, each doing a 1-word cycle → grants alternate 01,00,10,00,01… with no master granted twice in a row.
- **Watchdog (macro defined, `TIMEOUT_CYCLES`=8):** slave never acks → `s0_wb_err_o` pulses exactly once, 8 cycles after `stb` rose, with `m_wb_stb_o`=0 in that cycle. With the macro undefined, no err is ever seen.
- **Reset mid-burst:** assert `i_resetn`=0 during master 1's 2nd word → next edge `o_grant`=00, `m_wb_cyc_o`=0, `o_busy`=0. After release, a simultaneous request grants master 0 first.
